// File: rtl/wb_regfile.sv
// wb_regfile: Y86 writeback stage. Commits W-register results into the
// 15-entry architectural register file, serves two decode read ports,
// tracks RUN/STOP processor status and counts retired instructions.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   W_stat, W_icode       status / icode of the instruction in writeback
//   W_valE, W_dstE        E-port write data / destination (4'hF = none)
//   W_valM, W_dstM        M-port write data / destination (4'hF = none)
//   d_srcA, d_srcB        decode read addresses
//   d_rvalA, d_rvalB      combinational read data (0 for 4'hF or in reset)
//   W_stall               combinational hold request to the W register
//   prog_stat, halted     architectural status, high-in-STOP flag
//   retired_cnt           count of retired non-bubble instructions
module wb_regfile #(
  parameter int unsigned DATA_W = 64,
  parameter int unsigned CNT_W  = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [1:0]               W_stat,
  input  logic [3:0]               W_icode,
  input  logic signed [DATA_W-1:0] W_valE,
  input  logic signed [DATA_W-1:0] W_valM,
  input  logic [3:0]               W_dstE,
  input  logic [3:0]               W_dstM,
  input  logic [3:0]               d_srcA,
  input  logic [3:0]               d_srcB,
  output logic signed [DATA_W-1:0] d_rvalA,
  output logic signed [DATA_W-1:0] d_rvalB,
  output logic                     W_stall,
  output logic [1:0]               prog_stat,
  output logic                     halted,
  output logic [CNT_W-1:0]         retired_cnt
);

  localparam int unsigned NREG     = 15;
  localparam logic [3:0]  RNONE    = 4'hF;
  localparam logic [3:0]  I_NOP    = 4'h1;
  localparam logic [1:0]  STAT_AOK = 2'd0;

  typedef enum logic {S_RUN = 1'b0, S_STOP = 1'b1} state_t;

  state_t                    state_q, state_d;
  logic [1:0]                prog_stat_d;
  logic                      halted_d;
  logic                      wr_ok_c;
  logic                      retire_c;
  logic signed [DATA_W-1:0]  regs [NREG];

  // Next-state / control decode
  always_comb begin
    state_d     = state_q;
    prog_stat_d = prog_stat;
    halted_d    = halted;
    wr_ok_c     = 1'b0;
    retire_c    = 1'b0;
    case (state_q)
      S_RUN: begin
        retire_c = (W_icode != I_NOP);
        if (W_stat == STAT_AOK) begin
          wr_ok_c = 1'b1;
        end else begin
          // Faulting/halting instruction retires but writes nothing
          state_d     = S_STOP;
          prog_stat_d = W_stat;
          halted_d    = 1'b1;
        end
      end
      S_STOP: ;
      default: state_d = S_RUN;
    endcase
  end

  assign W_stall = (W_stat != STAT_AOK) | (state_q == S_STOP);

  // State, status and retirement counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RUN;
      prog_stat   <= STAT_AOK;
      halted      <= 1'b0;
      retired_cnt <= '0;
    end else begin
      state_q   <= state_d;
      prog_stat <= prog_stat_d;
      halted    <= halted_d;
      if (retire_c) retired_cnt <= retired_cnt + CNT_W'(1);
    end
  end

  // Register storage; M port assigned last so it wins on a shared destination
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(NREG); i++) regs[i] <= '0;
    end else if (wr_ok_c) begin
      for (int i = 0; i < int'(NREG); i++) begin
        if (W_dstE != RNONE && W_dstE == 4'(i)) regs[i] <= W_valE;
        if (W_dstM != RNONE && W_dstM == 4'(i)) regs[i] <= W_valM;
      end
    end
  end

  // Read ports: no write bypass; RNONE and reset read as zero
  always_comb begin
    d_rvalA = '0;
    d_rvalB = '0;
    for (int i = 0; i < int'(NREG); i++) begin
      if (rst_n && d_srcA == 4'(i)) d_rvalA = regs[i];
      if (rst_n && d_srcB == 4'(i)) d_rvalB = regs[i];
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// Testbench for wb_regfile (DATA_W = 64, CNT_W = 4 so counter wrap is reachable).
module tb_wb_regfile;

  localparam int unsigned DW = 64;
  localparam int unsigned CW = 4;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic [1:0]           W_stat;
  logic [3:0]           W_icode;
  logic signed [DW-1:0] W_valE, W_valM;
  logic [3:0]           W_dstE, W_dstM, d_srcA, d_srcB;
  logic signed [DW-1:0] d_rvalA, d_rvalB;
  logic                 W_stall;
  logic [1:0]           prog_stat;
  logic                 halted;
  logic [CW-1:0]        retired_cnt;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: architectural state in plain variables
  logic [DW-1:0] m_reg [15];
  bit            m_halt;
  logic [1:0]    m_stat;
  int            m_cnt;

  wb_regfile #(.DATA_W(DW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .W_stat(W_stat), .W_icode(W_icode),
    .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .d_srcA(d_srcA), .d_srcB(d_srcB),
    .d_rvalA(d_rvalA), .d_rvalB(d_rvalB),
    .W_stall(W_stall), .prog_stat(prog_stat),
    .halted(halted), .retired_cnt(retired_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] m_read(input logic [3:0] a);
    return (a == 4'hF) ? '0 : m_reg[a];
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 15; i++) m_reg[i] = '0;
    m_halt = 0; m_stat = 2'd0; m_cnt = 0;
  endfunction

  // One clock edge of architectural behaviour, from the current inputs
  function automatic void model_commit();
    if (!m_halt) begin
      if (W_icode != 4'h1) m_cnt = (m_cnt + 1) % (1 << CW);
      if (W_stat == 2'd0) begin
        if (W_dstE != 4'hF) m_reg[W_dstE] = W_valE;
        if (W_dstM != 4'hF) m_reg[W_dstM] = W_valM;
      end else begin
        m_halt = 1; m_stat = W_stat;
      end
    end
  endfunction

  // Time invariant between tasks: posedge + 1
  task automatic drive(input logic [1:0] st, input logic [3:0] ic,
                       input logic [DW-1:0] ve, input logic [DW-1:0] vm,
                       input logic [3:0] de, input logic [3:0] dm,
                       input logic [3:0] sa, input logic [3:0] sb);
    W_stat = st; W_icode = ic; W_valE = ve; W_valM = vm;
    W_dstE = de; W_dstM = dm; d_srcA = sa; d_srcB = sb;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    model_commit();
    #1;
  endtask

  task automatic idle();
    drive(2'd0, 4'h1, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF);
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    model_reset();
    #12;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    W_stat = 0; W_icode = 4'h1; W_valE = 0; W_valM = 0;
    W_dstE = 4'hF; W_dstM = 4'hF; d_srcA = 4'hF; d_srcB = 4'hF;
    rst_n = 1'b0;
    model_reset();
    #12;
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b exp 0", halted); end
    vectors++; if (prog_stat !== 2'd0) begin miscompares++; $display("FAIL reset_stat got %0d exp 0", prog_stat); end
    vectors++; if (retired_cnt !== 4'd0) begin miscompares++; $display("FAIL reset_cnt got %0d exp 0", retired_cnt); end
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(2'd0, 4'h1, '0, '0, 4'hF, 4'hF, 4'(i), 4'(14 - i));
      vectors++; if (d_rvalA !== 64'sd0) begin miscompares++; $display("FAIL reset_reg%0d got %h exp 0", i, d_rvalA); end
    end
  endtask

  task automatic test_single_write();
    drive(2'd0, 4'h3, 64'h1234, 64'h0, 4'h0, 4'hF, 4'h0, 4'h0);
    vectors++; if (d_rvalA !== 64'sd0) begin miscompares++; $display("FAIL e_write_same_cycle got %h exp 0", d_rvalA); end
    tick();
    idle(); d_srcA = 4'h0; #1;
    vectors++; if (d_rvalA !== 64'sh1234) begin miscompares++; $display("FAIL e_write_next got %h exp 1234", d_rvalA); end
    vectors++; if (retired_cnt !== 4'd1) begin miscompares++; $display("FAIL e_write_cnt got %0d exp 1", retired_cnt); end
  endtask

  task automatic test_dual_write();
    drive(2'd0, 4'hB, 64'sd5, -64'sd1, 4'h4, 4'h3, 4'h4, 4'h3);
    tick();
    idle(); d_srcA = 4'h4; d_srcB = 4'h3; #1;
    vectors++; if (d_rvalA !== 64'sd5) begin miscompares++; $display("FAIL dual_reg4 got %h exp 5", d_rvalA); end
    vectors++; if (d_rvalB !== 64'hFFFF_FFFF_FFFF_FFFF) begin miscompares++; $display("FAIL dual_reg3 got %h exp ffffffffffffffff", d_rvalB); end
    drive(2'd0, 4'hB, 64'sd7, 64'sd9, 4'h4, 4'h4, 4'h4, 4'h4);
    tick();
    idle(); d_srcA = 4'h4; d_srcB = 4'h4; #1;
    vectors++; if (d_rvalA !== 64'sd9) begin miscompares++; $display("FAIL m_wins got %h exp 9", d_rvalA); end
    vectors++; if (d_rvalB !== 64'sd9) begin miscompares++; $display("FAIL same_src_b got %h exp 9", d_rvalB); end
  endtask

  task automatic test_rnone();
    drive(2'd0, 4'h2, 64'hDEAD, 64'hBEEF, 4'hF, 4'hF, 4'hF, 4'h4);
    vectors++; if (d_rvalA !== 64'sd0) begin miscompares++; $display("FAIL rnone_read got %h exp 0", d_rvalA); end
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(2'd0, 4'h1, '0, '0, 4'hF, 4'hF, 4'(i), 4'hF);
      vectors++; if (d_rvalA !== m_read(4'(i))) begin miscompares++; $display("FAIL rnone_reg%0d got %h exp %h", i, d_rvalA, m_read(4'(i))); end
    end
  endtask

  task automatic test_halt();
    int c0;
    logic [DW-1:0] r5;
    c0 = m_cnt; r5 = m_reg[5];
    drive(2'd1, 4'h0, 64'sd55, 64'sd0, 4'h5, 4'hF, 4'h5, 4'hF);
    vectors++; if (W_stall !== 1'b1) begin miscompares++; $display("FAIL hlt_stall got %b exp 1", W_stall); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL hlt_early got %b exp 0", halted); end
    tick();
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL hlt_halted got %b exp 1", halted); end
    vectors++; if (prog_stat !== 2'd1) begin miscompares++; $display("FAIL hlt_stat got %0d exp 1", prog_stat); end
    vectors++; if (retired_cnt !== 4'((c0 + 1) % 16)) begin miscompares++; $display("FAIL hlt_cnt got %0d exp %0d", retired_cnt, (c0 + 1) % 16); end
    for (int k = 0; k < 3; k++) begin
      drive(2'd0, 4'h3, 64'sd100 + k, 64'sd0, 4'h5, 4'hF, 4'h5, 4'hF);
      vectors++; if (W_stall !== 1'b1) begin miscompares++; $display("FAIL stop_stall got %b exp 1", W_stall); end
      tick();
    end
    drive(2'd0, 4'h1, '0, '0, 4'hF, 4'hF, 4'h5, 4'hF);
    vectors++; if (d_rvalA !== r5) begin miscompares++; $display("FAIL stop_nowrite got %h exp %h", d_rvalA, r5); end
    vectors++; if (retired_cnt !== 4'((c0 + 1) % 16)) begin miscompares++; $display("FAIL stop_cnt got %0d exp %0d", retired_cnt, (c0 + 1) % 16); end
  endtask

  task automatic test_adr_reset();
    do_reset();
    drive(2'd0, 4'h3, 64'sd77, 64'sd0, 4'h2, 4'hF, 4'h2, 4'hF);
    tick();
    drive(2'd2, 4'h5, 64'sd0, 64'sd99, 4'hF, 4'h2, 4'h2, 4'hF);
    tick();
    idle(); d_srcA = 4'h2; #1;
    vectors++; if (d_rvalA !== 64'sd77) begin miscompares++; $display("FAIL adr_nowrite got %h exp 77", d_rvalA); end
    vectors++; if (prog_stat !== 2'd2) begin miscompares++; $display("FAIL adr_stat got %0d exp 2", prog_stat); end
    // Mid-cycle reset with a live AOK write presented
    drive(2'd0, 4'h3, 64'sd42, 64'sd43, 4'h2, 4'h6, 4'h2, 4'h6);
    #2; rst_n = 1'b0; model_reset(); #1;
    vectors++; if (d_rvalA !== 64'sd0) begin miscompares++; $display("FAIL rst_read_a got %h exp 0", d_rvalA); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL rst_halted got %b exp 0", halted); end
    vectors++; if (retired_cnt !== 4'd0) begin miscompares++; $display("FAIL rst_cnt got %0d exp 0", retired_cnt); end
    @(posedge clk); #3;
    idle();
    @(negedge clk); rst_n = 1'b1;
    tick();
    for (int i = 0; i < 15; i++) begin
      drive(2'd0, 4'h1, '0, '0, 4'hF, 4'hF, 4'(i), 4'hF);
      vectors++; if (d_rvalA !== 64'sd0) begin miscompares++; $display("FAIL rst_reg%0d got %h exp 0", i, d_rvalA); end
    end
    vectors++; if (prog_stat !== 2'd0) begin miscompares++; $display("FAIL rst_stat got %0d exp 0", prog_stat); end
  endtask

  task automatic test_bubbles();
    int c0;
    drive(2'd0, 4'h6, 64'sd1, 64'sd0, 4'h1, 4'hF, 4'hF, 4'hF);
    tick();
    c0 = m_cnt;
    for (int k = 0; k < 10; k++) begin
      drive(2'd0, 4'h1, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF);
      tick();
    end
    vectors++; if (retired_cnt !== 4'(c0)) begin miscompares++; $display("FAIL bubble_cnt got %0d exp %0d", retired_cnt, c0); end
  endtask

  task automatic test_wrap();
    do_reset();
    for (int k = 0; k < 15; k++) begin
      drive(2'd0, 4'h0, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF);
      tick();
    end
    vectors++; if (retired_cnt !== 4'd15) begin miscompares++; $display("FAIL wrap_15 got %0d exp 15", retired_cnt); end
    drive(2'd0, 4'h0, '0, '0, 4'hF, 4'hF, 4'hF, 4'hF);
    tick();
    vectors++; if (retired_cnt !== 4'd0) begin miscompares++; $display("FAIL wrap_0 got %0d exp 0", retired_cnt); end
  endtask

  task automatic test_random();
    logic [1:0] st;
    logic [3:0] ic, de, dm, sa, sb;
    logic [DW-1:0] ve, vm;
    int stop_cycles;
    do_reset();
    stop_cycles = 0;
    for (int k = 0; k < 400; k++) begin
      st = ($urandom_range(0, 39) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
      ic = 4'($urandom_range(0, 11));
      ve = {$urandom, $urandom};
      vm = {$urandom, $urandom};
      de = 4'($urandom_range(0, 15));
      dm = ($urandom_range(0, 3) == 0) ? de : 4'($urandom_range(0, 15));
      sa = 4'($urandom_range(0, 15));
      sb = ($urandom_range(0, 7) == 0) ? sa : 4'($urandom_range(0, 15));
      drive(st, ic, ve, vm, de, dm, sa, sb);
      vectors++; if (d_rvalA !== m_read(sa)) begin miscompares++; $display("FAIL rnd_rvalA k=%0d got %h exp %h", k, d_rvalA, m_read(sa)); end
      vectors++; if (d_rvalB !== m_read(sb)) begin miscompares++; $display("FAIL rnd_rvalB k=%0d got %h exp %h", k, d_rvalB, m_read(sb)); end
      vectors++; if (W_stall !== ((st != 2'd0) || m_halt)) begin miscompares++; $display("FAIL rnd_stall k=%0d got %b exp %b", k, W_stall, (st != 2'd0) || m_halt); end
      tick();
      vectors++; if (halted !== m_halt) begin miscompares++; $display("FAIL rnd_halted k=%0d got %b exp %b", k, halted, m_halt); end
      vectors++; if (prog_stat !== m_stat) begin miscompares++; $display("FAIL rnd_stat k=%0d got %0d exp %0d", k, prog_stat, m_stat); end
      vectors++; if (retired_cnt !== 4'(m_cnt)) begin miscompares++; $display("FAIL rnd_cnt k=%0d got %0d exp %0d", k, retired_cnt, m_cnt); end
      if (m_halt) stop_cycles++;
      if (stop_cycles > 4) begin
        do_reset();
        stop_cycles = 0;
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_dual_write();
    test_rnone();
    test_halt();
    test_adr_reset();
    test_bubbles();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end

endmodule
